ysyx_25040101_wbu: RTL and testbench
====================================

# ysyx_25040101_wbu

Writeback unit for the single-issue RV32 core. It tracks in-flight destination registers in a scoreboard fed by decode and accepts results from the ALU and the LSU over valid/ready handshakes. It arbitrates the two result sources onto the register file's single write port and reports read-after-write hazards back to decode. It writes into `ysyx_25040101_regs` (`rd_wen`, `rd_addr_i`, `rd_data_i`).

## Interface
Parameters:
- `XLEN`, 32: data width.
- `STARVE_MAX`, 3: number of consecutive lost ALU arbitration cycles after which the ALU gets priority.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset; one clock, asynchronous, active-low.
- `issue_valid_i` in 1: decode issues an instruction that writes `issue_rd_i`.
- `issue_rd_i` in 5: destination register of the issued instruction.
- `issue_ready_o` out 1: issue accepted this cycle.
- `alu_valid_i` in 1: ALU result available.
- `alu_rd_i` in 5: ALU result destination.
- `alu_data_i` in XLEN: ALU result data.
- `alu_ready_o` out 1: ALU result accepted.
- `lsu_valid_i` in 1: LSU result available.
- `lsu_rd_i` in 5: LSU result destination.
- `lsu_data_i` in XLEN: LSU result data.
- `lsu_ready_o` out 1: LSU result accepted.
- `rs1_addr_i` in 5: decode source address 1.
- `rs2_addr_i` in 5: decode source address 2.
- `raw_stall_o` out 1: a source register is pending; decode must hold.
- `rd_wen_o` out 1: register-file write enable, registered.
- `rd_addr_o` out 5: register-file write address, registered.
- `rd_data_o` out XLEN: register-file write data, registered.
- `busy_o` out 32: scoreboard bits; bit 0 is always 0.
- `inflight_o` out 6: number of set busy bits.

## Operation
- **Scoreboard.** `busy[i]` is set at the clock edge where issue handshakes (`issue_valid_i && issue_ready_o`) with `issue_rd_i == i`, `i != 0`.
- **Busy clear.** `busy[i]` is cleared at the edge where `rd_wen_o == 1 && rd_addr_o == i`, which is the same edge the register file captures the data. This leaves no stale-read window.
- **Issue ready.** `issue_ready_o = !busy[issue_rd_i] || issue_rd_i == 0`. It evaluates the current `busy` only, so issue to a register being cleared this cycle waits one cycle (WAW-safe). Issue with rd=0 is accepted and sets nothing.
- **Hazard stall.** `raw_stall_o = busy[rs1_addr_i] | busy[rs2_addr_i]`. This is combinational, and x0 never stalls.
- **Arbitration.** Fixed LSU priority with a starvation guard, using counter `starve` (0..STARVE_MAX):
  - `lsu_ready_o = !(starve == STARVE_MAX && alu_valid_i)`.
  - `alu_ready_o = !lsu_valid_i || starve == STARVE_MAX`.
  - `starve` increments, saturating, each cycle `alu_valid_i && !alu_ready_o`. It resets to 0 on an ALU handshake.
- **Write path.** The accepted source (at most one per cycle) loads the output registers: `rd_wen_o <= (rd != 0)`, `rd_addr_o <= rd`, `rd_data_o <= data`. With no handshake, `rd_wen_o <= 0` and addr/data hold. The output never backpressures.
- **Unexpected completion.** A completion to a non-busy rd is still written and causes no busy change.
- **Completion to x0.** This is consumed with no write.
- **In-flight count.** `inflight_o` is +1 on a set, -1 on a clear, unchanged when both happen. It always equals popcount(busy).

## Timing
- Reset (`rst_n` low, asynchronous): `busy`=0, `inflight_o`=0, `starve`=0, `rd_wen_o`=0, `rd_addr_o`=0, `rd_data_o`=0. Pending entries are discarded. Any handshake in the reset cycle is lost.
- Result handshake in cycle N → `rd_wen_o` high in N+1 → register file updated and busy cleared at the end of N+1 → `raw_stall_o` for that rd low in N+2.
- Issue handshake in cycle N → `busy` set and `raw_stall_o` visible from N+1.
- Same-edge set and clear of different registers: both take effect, and `inflight_o` is unchanged.
- Sustained throughput: one write per cycle. The ALU is guaranteed a grant within STARVE_MAX+1 cycles of asserting valid.

## Structure
- **Shared package `ysyx_25040101_pkg`:** `XLEN`, `REG_AW` (5), `NREG` (32), `STARVE_MAX_DEF`.
- **Sub-module `ysyx_25040101_scoreboard`:** busy vector, set/clear logic, in-flight counter, and the RAW/WAW lookups.
- **`ysyx_25040101_wbu` itself:** the arbiter, the starvation counter and the output registers.

## Test plan
- **Reset mid-operation.** Issue rd=5, then assert `rst_n`=0 → `busy_o`=0, `inflight_o`=0, `rd_wen_o`=0 immediately (asynchronously).
- **ALU round trip.** Issue rd=5; ALU result rd=5, data 0xDEADBEEF at cycle N → `rd_wen_o`=1, addr 5, data 0xDEADBEEF at N+1; `raw_stall_o` (rs1=5) is 1 through N+1 and 0 at N+2; `inflight_o` goes 1→0.
- **Simultaneous completion and starvation.** ALU rd=3 and LSU rd=4 both valid in the same cycle → LSU is written first and ALU the next cycle. With LSU valid continuously, the ALU is granted on the 4th cycle (STARVE_MAX=3).
- **WAW block.** Issue rd=7 while `busy[7]`=1 → `issue_ready_o`=0 until the cycle after the rd=7 write pulse.
- **x0 handling.** Issue and ALU completion with rd=0 → handshakes complete, `rd_wen_o` stays 0, `busy_o[0]`=0, `raw_stall_o`=0 for rs1=0.
- **In-flight accounting.** Issue rd=1,2,3 back-to-back → `inflight_o`=3. Complete rd=2 while issuing rd=9 → `inflight_o` stays 3 and `busy_o`=0x20A.

Source files
------------

// File: rtl/ysyx_25040101_pkg.sv
// Shared constants and types for the writeback unit.
// Covers register-file geometry, the default starvation threshold and the result-source encoding.
package ysyx_25040101_pkg;
    localparam int XLEN           = 32;
    localparam int REG_AW         = 5;
    localparam int NREG           = 32;
    localparam int STARVE_MAX_DEF = 3;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LSU  = 2'd2
    } src_e;
endpackage

// File: rtl/ysyx_25040101_scoreboard.sv
// Busy-register scoreboard: set on issue, clear on register-file write.
// Also provides the in-flight count and the RAW and WAW lookups.
module ysyx_25040101_scoreboard
    import ysyx_25040101_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_rd,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_rd,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              issue_ready,
    output logic              raw_stall,
    output logic [NREG-1:0]   busy,
    output logic [REG_AW:0]   inflight
);
    logic [NREG-1:0] busy_q, set_mask, clr_mask;
    logic [REG_AW:0] inflight_q;
    logic            inc, dec;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && set_rd != '0) set_mask[set_rd] = 1'b1;
        if (clr_en && clr_rd != '0) clr_mask[clr_rd] = 1'b1;
    end

    // Set wins over clear on the same bit, so count only the bits that really change.
    assign inc = |(set_mask & ~busy_q);
    assign dec = |(clr_mask & busy_q & ~set_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            inflight_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_mask) | set_mask;
            case ({inc, dec})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign issue_ready = !busy_q[issue_rd] || issue_rd == '0;
    assign raw_stall   = busy_q[rs1_addr] | busy_q[rs2_addr];
    assign busy        = busy_q;
    assign inflight    = inflight_q;
endmodule

// File: rtl/ysyx_25040101_wbu.sv
// Writeback unit: arbitrates ALU and LSU results onto the single register-file write port.
// LSU has priority unless the ALU has been starved for STARVE_MAX cycles.
module ysyx_25040101_wbu #(
    parameter int XLEN       = ysyx_25040101_pkg::XLEN,
    parameter int STARVE_MAX = ysyx_25040101_pkg::STARVE_MAX_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               issue_valid_i,
    input  logic [ysyx_25040101_pkg::REG_AW-1:0] issue_rd_i,
    output logic                               issue_ready_o,
    input  logic                               alu_valid_i,
    input  logic [ysyx_25040101_pkg::REG_AW-1:0] alu_rd_i,
    input  logic [XLEN-1:0]                    alu_data_i,
    output logic                               alu_ready_o,
    input  logic                               lsu_valid_i,
    input  logic [ysyx_25040101_pkg::REG_AW-1:0] lsu_rd_i,
    input  logic [XLEN-1:0]                    lsu_data_i,
    output logic                               lsu_ready_o,
    input  logic [ysyx_25040101_pkg::REG_AW-1:0] rs1_addr_i,
    input  logic [ysyx_25040101_pkg::REG_AW-1:0] rs2_addr_i,
    output logic                               raw_stall_o,
    output logic                               rd_wen_o,
    output logic [ysyx_25040101_pkg::REG_AW-1:0] rd_addr_o,
    output logic [XLEN-1:0]                    rd_data_o,
    output logic [ysyx_25040101_pkg::NREG-1:0] busy_o,
    output logic [ysyx_25040101_pkg::REG_AW:0] inflight_o
);
    import ysyx_25040101_pkg::*;

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

    logic [SW-1:0] starve;
    logic          sat, alu_hs, lsu_hs;
    src_e          grant;

    assign sat         = (starve == STARVE_SAT);
    assign lsu_ready_o = !(sat && alu_valid_i);
    assign alu_ready_o = !lsu_valid_i || sat;
    assign alu_hs      = alu_valid_i && alu_ready_o;
    assign lsu_hs      = lsu_valid_i && lsu_ready_o;

    // The ready equations make the two handshakes mutually exclusive.
    always_comb begin
        grant = SRC_NONE;
        if (alu_hs)      grant = SRC_ALU;
        else if (lsu_hs) grant = SRC_LSU;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (alu_hs) begin
            starve <= '0;
        end else if (alu_valid_i && !sat) begin
            starve <= starve + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_wen_o  <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
        end else begin
            case (grant)
                SRC_ALU: begin
                    rd_wen_o  <= (alu_rd_i != '0);
                    rd_addr_o <= alu_rd_i;
                    rd_data_o <= alu_data_i;
                end
                SRC_LSU: begin
                    rd_wen_o  <= (lsu_rd_i != '0);
                    rd_addr_o <= lsu_rd_i;
                    rd_data_o <= lsu_data_i;
                end
                default: rd_wen_o <= 1'b0;
            endcase
        end
    end

    // Busy clears on the same edge the register file captures the write.
    ysyx_25040101_scoreboard u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_en      (issue_valid_i && issue_ready_o),
        .set_rd      (issue_rd_i),
        .clr_en      (rd_wen_o),
        .clr_rd      (rd_addr_o),
        .issue_rd    (issue_rd_i),
        .rs1_addr    (rs1_addr_i),
        .rs2_addr    (rs2_addr_i),
        .issue_ready (issue_ready_o),
        .raw_stall   (raw_stall_o),
        .busy        (busy_o),
        .inflight    (inflight_o)
    );
endmodule

// File: tb/tb_ysyx_25040101_wbu.sv
// Directed bench for the writeback unit.
// Each step drives inputs after a clock edge and checks outputs mid-cycle against hand-computed values.
module tb_ysyx_25040101_wbu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        lsu_ready;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        raw_stall;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] busy;
    logic [5:0]  inflight;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_25040101_wbu #(.XLEN(32), .STARVE_MAX(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .issue_ready_o (issue_ready),
        .alu_valid_i   (alu_valid),
        .alu_rd_i      (alu_rd),
        .alu_data_i    (alu_data),
        .alu_ready_o   (alu_ready),
        .lsu_valid_i   (lsu_valid),
        .lsu_rd_i      (lsu_rd),
        .lsu_data_i    (lsu_data),
        .lsu_ready_o   (lsu_ready),
        .rs1_addr_i    (rs1),
        .rs2_addr_i    (rs2),
        .raw_stall_o   (raw_stall),
        .rd_wen_o      (rd_wen),
        .rd_addr_o     (rd_addr),
        .rd_data_o     (rd_data),
        .busy_o        (busy),
        .inflight_o    (inflight)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_busy", busy, 32'h0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_wen", 32'(rd_wen), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        chk("rst_data", rd_data, 32'h0);
        tick(); tick();
        rst_n = 1'b1;

        // Reset mid-operation: busy[5] set and a write pulse in flight
        issue_valid = 1'b1; issue_rd = 5'd5; #1;
        chk("mid_issue_ready", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1111_2222;
        tick();
        alu_valid = 1'b0;
        chk("mid_busy_pre", busy, 32'h20);
        chk("mid_wen_pre", 32'(rd_wen), 32'd1);
        rst_n = 1'b0; #1;
        chk("mid_busy_rst", busy, 32'h0);
        chk("mid_inflight_rst", 32'(inflight), 32'd0);
        chk("mid_wen_rst", 32'(rd_wen), 32'd0);
        chk("mid_data_rst", rd_data, 32'h0);
        #1 rst_n = 1'b1;
        tick();

        // ALU round trip
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        issue_valid = 1'b0; rs1 = 5'd5; #1;
        chk("rt_busy", busy, 32'h20);
        chk("rt_inflight1", 32'(inflight), 32'd1);
        chk("rt_stall_n0", 32'(raw_stall), 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF; #1;
        chk("rt_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0; #1;
        chk("rt_wen_n1", 32'(rd_wen), 32'd1);
        chk("rt_addr_n1", 32'(rd_addr), 32'd5);
        chk("rt_data_n1", rd_data, 32'hDEAD_BEEF);
        chk("rt_stall_n1", 32'(raw_stall), 32'd1);
        chk("rt_inflight_n1", 32'(inflight), 32'd1);
        tick();
        chk("rt_wen_n2", 32'(rd_wen), 32'd0);
        chk("rt_stall_n2", 32'(raw_stall), 32'd0);
        chk("rt_inflight_n2", 32'(inflight), 32'd0);
        chk("rt_data_hold", rd_data, 32'hDEAD_BEEF);
        rs1 = 5'd0;

        // WAW block on rd=7
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        #1;
        chk("waw_ready_busy", 32'(issue_ready), 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0077;
        tick();
        alu_valid = 1'b0; #1;
        chk("waw_wen", 32'(rd_wen), 32'd1);
        chk("waw_ready_pulse", 32'(issue_ready), 32'd0);
        tick();
        chk("waw_busy_clear", busy, 32'h0);
        chk("waw_ready_after", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("waw_busy_reissue", busy, 32'h80);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0;
        tick();
        alu_valid = 1'b0;
        tick();
        chk("waw_drained", busy, 32'h0);

        // Simultaneous ALU and LSU completion: LSU first
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h0000_0044; #1;
        chk("sim_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("sim_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        lsu_valid = 1'b0; #1;
        chk("sim_first_addr", 32'(rd_addr), 32'd4);
        chk("sim_first_data", rd_data, 32'h44);
        chk("sim_alu_ready2", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("sim_second_addr", 32'(rd_addr), 32'd3);
        chk("sim_second_data", rd_data, 32'h33);
        chk("sim_busy", busy, 32'h0);
        tick();

        // Starvation guard: continuous LSU, ALU granted on the 4th cycle
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h0000_0088;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_00AA;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("stv_alu_ready_c%0d", c), 32'(alu_ready), (c == 3) ? 32'd1 : 32'd0);
            chk($sformatf("stv_lsu_ready_c%0d", c), 32'(lsu_ready), (c == 3) ? 32'd0 : 32'd1);
            tick();
            if (c < 3) chk($sformatf("stv_addr_c%0d", c), 32'(rd_addr), 32'd8);
        end
        alu_valid = 1'b0;
        chk("stv_alu_addr", 32'(rd_addr), 32'd10);
        chk("stv_alu_data", rd_data, 32'hAA);
        #1;
        chk("stv_lsu_back", 32'(lsu_ready), 32'd1);
        tick();
        lsu_valid = 1'b0;
        chk("stv_lsu_addr", 32'(rd_addr), 32'd8);
        tick();

        // x0 handling
        issue_valid = 1'b1; issue_rd = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
        rs1 = 5'd0; #1;
        chk("x0_issue_ready", 32'(issue_ready), 32'd1);
        chk("x0_alu_ready", 32'(alu_ready), 32'd1);
        chk("x0_stall", 32'(raw_stall), 32'd0);
        tick();
        issue_valid = 1'b0; alu_valid = 1'b0;
        chk("x0_wen", 32'(rd_wen), 32'd0);
        chk("x0_busy", busy, 32'h0);
        chk("x0_inflight", 32'(inflight), 32'd0);
        tick();
        chk("x0_wen2", 32'(rd_wen), 32'd0);

        // In-flight accounting with same-edge set and clear
        issue_valid = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            issue_rd = 5'(r);
            tick();
        end
        issue_valid = 1'b0;
        chk("ifl_three", 32'(inflight), 32'd3);
        chk("ifl_busy_e", busy, 32'h0000_000E);
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h0000_0222;
        tick();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd9;
        chk("ifl_wen2", 32'(rd_wen), 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("ifl_same_edge", 32'(inflight), 32'd3);
        chk("ifl_busy_20a", busy, 32'h0000_020A);
        rs1 = 5'd1; rs2 = 5'd9; #1;
        chk("ifl_stall_hit", 32'(raw_stall), 32'd1);
        rs1 = 5'd2; rs2 = 5'd0; #1;
        chk("ifl_stall_miss", 32'(raw_stall), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
